// File: rtl/timer_module_pkg.sv
// -----------------------------------------------------------------------------
// timer_module_pkg
// Shared processor definitions for the programmable timer peripheral:
//   - register address map (TMR_CTRL .. TMR_MISSED)
//   - CTRL bit positions
//   - timer FSM state encoding
//   - timer interrupt vector address, kept here so the timer and the
//     interrupt controller agree on where the timer subroutine lives
// -----------------------------------------------------------------------------
package timer_module_pkg;

  // Register address map
  localparam logic [2:0] TMR_CTRL      = 3'd0;
  localparam logic [2:0] TMR_STATUS    = 3'd1;
  localparam logic [2:0] TMR_PRESCALE  = 3'd2;
  localparam logic [2:0] TMR_RELOAD_LO = 3'd3;
  localparam logic [2:0] TMR_RELOAD_HI = 3'd4;
  localparam logic [2:0] TMR_COUNT_LO  = 3'd5;
  localparam logic [2:0] TMR_COUNT_HI  = 3'd6;
  localparam logic [2:0] TMR_MISSED    = 3'd7;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  // Timer FSM state encoding
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_e;

  // Interrupt controller vector for the timer subroutine
  localparam logic [9:0] TIMER_VECTOR_ADDR = 10'b1111111010;

endpackage

// File: rtl/timer_module_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the system clock by (prescale_i + 1) while run_i is high.
//   clk        in  system clock
//   reset      in  synchronous active-high reset
//   run_i      in  prescaler advances only while high; holds otherwise
//   clear_i    in  forces the count back to 0 and suppresses the tick
//   prescale_i in  divide value; tick every prescale_i+1 cycles
//   tick_o     out one-cycle tick (combinational from the count)
// -----------------------------------------------------------------------------
module timer_prescaler
  #(
    parameter int unsigned PRESC_W = 8
  )
  (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_i,
    input  logic               clear_i,
    input  logic [PRESC_W-1:0] prescale_i,
    output logic               tick_o
  );

  logic [PRESC_W-1:0] presc_cnt_q;
  logic               wrap_s;

  // Using >= rather than == means a PRESCALE written below the running
  // count wraps on the next cycle instead of counting all the way round.
  assign wrap_s = (presc_cnt_q >= prescale_i);
  assign tick_o = run_i & ~clear_i & wrap_s;

  // Prescaler count: cleared on commit, wraps on tick, otherwise counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_q <= {PRESC_W{1'b0}};
    end else if (clear_i) begin
      presc_cnt_q <= {PRESC_W{1'b0}};
    end else if (run_i) begin
      if (wrap_s) begin
        presc_cnt_q <= {PRESC_W{1'b0}};
      end else begin
        presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/timer_module.sv
// -----------------------------------------------------------------------------
// timer_module
// Programmable down-counting timer. Drives a one-cycle request pulse into
// the interrupt controller's i_timer input on expiry.
//   clk     in  system clock
//   reset   in  synchronous active-high reset
//   we      in  register write strobe
//   addr    in  register select (see timer_module_pkg address map)
//   wdata   in  register write data
//   rdata   out register read data, combinational from addr
//   i_timer out registered one-cycle interrupt request
// Build option: define TIMER_MISSED_COUNT_EN to add the saturating MISSED
// counter at address 7 (reads 0 and ignores writes when undefined).
// -----------------------------------------------------------------------------
module timer_module
  import timer_module_pkg::*;
  #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PRESC_W = 8
  )
  (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              i_timer
  );

  localparam int unsigned COUNT_W = 2 * DATA_W;

  tmr_state_e         state_q;
  logic [2:0]         ctrl_q;
  logic               flag_q;
  logic [PRESC_W-1:0] prescale_q;
  logic [DATA_W-1:0]  reload_lo_q;
  logic [COUNT_W-1:0] reload_q;
  logic [COUNT_W-1:0] count_q;
  logic               i_timer_q;

  logic wr_ctrl_s;
  logic ctrl_stop_s;
  logic commit_s;
  logic w1c_s;
  logic run_s;
  logic tick_s;
  logic expiry_s;
  logic oneshot_done_s;

  assign wr_ctrl_s   = we & (addr == TMR_CTRL);
  // A CTRL write clearing en beats anything the counter would do that cycle.
  assign ctrl_stop_s = wr_ctrl_s & ~wdata[CTRL_EN];
  assign commit_s    = we & (addr == TMR_RELOAD_HI);
  assign w1c_s       = we & (addr == TMR_STATUS) & wdata[0];
  assign run_s       = (state_q == RUN) & ~ctrl_stop_s;
  // tick_s is already masked by commit and stop, so expiry inherits both.
  assign expiry_s    = tick_s & (count_q == {COUNT_W{1'b0}});
  // A same-cycle CTRL write keeps control of en/state over a one-shot end.
  assign oneshot_done_s = expiry_s & ~ctrl_q[CTRL_PERIODIC] & ~wr_ctrl_s;

  timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run_s),
    .clear_i    (commit_s),
    .prescale_i (prescale_q),
    .tick_o     (tick_s)
  );

  // Timer FSM, configuration registers, counter, flag and interrupt pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ctrl_q      <= 3'b000;
      flag_q      <= 1'b0;
      prescale_q  <= {PRESC_W{1'b0}};
      reload_lo_q <= {DATA_W{1'b0}};
      reload_q    <= {COUNT_W{1'b0}};
      count_q     <= {COUNT_W{1'b0}};
      i_timer_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (wr_ctrl_s && wdata[CTRL_EN]) state_q <= RUN;
        RUN:  if (ctrl_stop_s || oneshot_done_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (wr_ctrl_s) begin
        ctrl_q <= wdata[2:0];
      end else if (oneshot_done_s) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end

      if (we && (addr == TMR_PRESCALE))  prescale_q  <= PRESC_W'(wdata);
      if (we && (addr == TMR_RELOAD_LO)) reload_lo_q <= wdata;

      if (commit_s) begin
        reload_q <= {wdata, reload_lo_q};
        count_q  <= {wdata, reload_lo_q};
      end else if (expiry_s) begin
        if (ctrl_q[CTRL_PERIODIC]) count_q <= reload_q;
      end else if (tick_s) begin
        count_q <= count_q - COUNT_W'(1);
      end

      // Set beats a coincident W1C.
      if (expiry_s) begin
        flag_q <= 1'b1;
      end else if (w1c_s) begin
        flag_q <= 1'b0;
      end

      // Back-to-back expiries never stretch the request beyond one cycle.
      i_timer_q <= expiry_s & ctrl_q[CTRL_IRQ_EN] & ~i_timer_q;
    end
  end

  assign i_timer = i_timer_q;

`ifdef TIMER_MISSED_COUNT_EN
  logic [7:0] missed_q;

  // Unserviced-expiry counter: saturates at 255, any write to addr 7 clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      missed_q <= 8'd0;
    end else if (we && (addr == TMR_MISSED)) begin
      missed_q <= 8'd0;
    end else if (expiry_s && flag_q && (missed_q != 8'hFF)) begin
      missed_q <= missed_q + 8'd1;
    end
  end
`endif

  // Register read mux.
  always_comb begin
    rdata = {DATA_W{1'b0}};
    case (addr)
      TMR_CTRL:      rdata = DATA_W'(ctrl_q);
      TMR_STATUS:    rdata = DATA_W'(flag_q);
      TMR_PRESCALE:  rdata = DATA_W'(prescale_q);
      TMR_RELOAD_LO: rdata = reload_lo_q;
      TMR_RELOAD_HI: rdata = reload_q[COUNT_W-1:DATA_W];
      TMR_COUNT_LO:  rdata = count_q[DATA_W-1:0];
      TMR_COUNT_HI:  rdata = count_q[COUNT_W-1:DATA_W];
`ifdef TIMER_MISSED_COUNT_EN
      TMR_MISSED:    rdata = DATA_W'(missed_q);
`endif
      default:       rdata = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_timer_module.sv
module tb_timer_module;

  logic       clk;
  logic       reset;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       i_timer;

  int n_checks = 0;
  int n_errors = 0;

`ifdef TIMER_MISSED_COUNT_EN
  localparam int MISSED_SAT   = 255;
  localparam int MISSED_AFTER = 1;
`else
  localparam int MISSED_SAT   = 0;
  localparam int MISSED_AFTER = 0;
`endif

  timer_module dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .i_timer (i_timer)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read is combinational; called at a negedge, settles well before posedge.
  task automatic chk_rd(input string tag, input logic [2:0] a, input int exp);
    addr = a;
    #1;
    chk(tag, {8'h00, rdata}, exp[15:0]);
  endtask

  // Called at a negedge: write lands on the next posedge, returns at the
  // following negedge.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_reset();
    we = 1'b0; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int p, r, per, exp_cnt;
    we = 1'b0; addr = 3'd0; wdata = 8'h00; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state: every register reads 0, no request for 20 cycles
    for (int a = 0; a < 8; a++) chk_rd($sformatf("reset_rd%0d", a), 3'(a), 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("reset_irq", i_timer, 0);
    end

    // Periodic, PRESCALE=0, RELOAD=3: pulse every 4 cycles, COUNT 2,1,0,3...
    wr(3'd2, 8'd0); wr(3'd3, 8'd3); wr(3'd4, 8'd0); wr(3'd0, 8'h07);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("per_irq_k%0d", k), i_timer, (k % 4 == 0) ? 1 : 0);
      chk_rd($sformatf("per_cnt_k%0d", k), 3'd5, (k % 4 == 0) ? 3 : 3 - (k % 4));
      if (k == 4) chk_rd("per_status", 3'd1, 1);
    end
    chk_rd("per_ctrl", 3'd0, 7);

    // Reset just before an expiry edge: no pulse, everything back to 0
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_irq", i_timer, 0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) chk_rd($sformatf("midreset_rd%0d", a), 3'(a), 0);

    // One-shot, PRESCALE=2, RELOAD=1: single pulse 6 cycles after enable
    wr(3'd2, 8'd2); wr(3'd3, 8'd1); wr(3'd4, 8'd0); wr(3'd0, 8'h05);
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      chk($sformatf("oneshot_irq_k%0d", k), i_timer, (k == 6) ? 1 : 0);
    end
    chk_rd("oneshot_ctrl", 3'd0, 8'h04);
    chk_rd("oneshot_cnt_lo", 3'd5, 0);
    chk_rd("oneshot_cnt_hi", 3'd6, 0);
    chk_rd("oneshot_status", 3'd1, 1);

    // CTRL disable in the exact expiry cycle: write wins
    do_reset();
    wr(3'd2, 8'd0); wr(3'd3, 8'd3); wr(3'd4, 8'd0); wr(3'd0, 8'h07);
    repeat (3) @(negedge clk);
    wr(3'd0, 8'h00);
    chk("stop_irq", i_timer, 0);
    chk_rd("stop_status", 3'd1, 0);
    chk_rd("stop_cnt", 3'd5, 0);
    chk_rd("stop_ctrl", 3'd0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stop_irq_hold", i_timer, 0);
      chk_rd("stop_cnt_hold", 3'd5, 0);
    end

    // irq_en=0: flag still sets; W1C coincident with expiry loses to the set
    wr(3'd4, 8'd0); wr(3'd0, 8'h03);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("noirq_irq", i_timer, 0);
    end
    chk_rd("noirq_status", 3'd1, 1);
    repeat (3) @(negedge clk);
    wr(3'd1, 8'h01);
    chk("w1c_race_irq", i_timer, 0);
    chk_rd("w1c_race_status", 3'd1, 1);
    chk_rd("w1c_race_missed", 3'd7, MISSED_AFTER);
    wr(3'd1, 8'h01);
    chk_rd("w1c_clear_status", 3'd1, 0);
    wr(3'd0, 8'h00);

    // RELOAD=0 periodic, STATUS never cleared for 300 cycles
    do_reset();
    wr(3'd2, 8'd0); wr(3'd3, 8'd0); wr(3'd4, 8'd0); wr(3'd0, 8'h03);
    repeat (300) @(negedge clk);
    chk_rd("missed_sat", 3'd7, MISSED_SAT);
    chk_rd("missed_status", 3'd1, 1);
    wr(3'd7, 8'h00);
    chk_rd("missed_clear", 3'd7, 0);

    // Randomized periodic runs: period = (reload+1)*(prescale+1)
    for (int it = 0; it < 6; it++) begin
      do_reset();
      p = int'($urandom_range(0, 3));
      r = int'($urandom_range(1, 5));
      per = (r + 1) * (p + 1);
      wr(3'd2, 8'(p)); wr(3'd3, 8'(r)); wr(3'd4, 8'd0); wr(3'd0, 8'h07);
      for (int k = 1; k <= 3 * per; k++) begin
        @(negedge clk);
        exp_cnt = r - ((k / (p + 1)) % (r + 1));
        chk($sformatf("rnd%0d_p%0d_r%0d_irq_k%0d", it, p, r, k), i_timer, (k % per == 0) ? 1 : 0);
        chk_rd($sformatf("rnd%0d_p%0d_r%0d_cnt_k%0d", it, p, r, k), 3'd5, exp_cnt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
